// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter (IF fetch vs MEM load/store) for one fixed-latency synchronous memory.
// Data requests win by default; a starvation counter forces an IF grant after STARVE_MAX data grants.
module mem_port_arbiter #(
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ready,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_ready,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        stall_if,
    output logic        stall_mem,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    localparam logic [3:0] LAT_INIT   = 4'(MEM_LAT);
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    state_t     state, next_state;
    logic       owner_d;
    logic       acc_we;
    logic [3:0] lat_cnt;
    logic [3:0] starve_cnt;
    logic       grant_req;
    logic       grant_if;
    logic       capture;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // mem_en is still high only in the first WAIT cycle, so the countdown starts one cycle later;
    // that lands the capture on the cycle where the memory drives valid read data.
    always_comb begin
        next_state = state;
        grant_req  = 1'b0;
        grant_if   = 1'b0;
        capture    = 1'b0;
        case (state)
            IDLE: begin
                if (if_req || d_req) begin
                    grant_req  = 1'b1;
                    grant_if   = if_req && (!d_req || (starve_cnt == STARVE_LIM));
                    next_state = WAIT;
                end
            end
            WAIT: begin
                if (!mem_en && (lat_cnt == 4'd1)) begin
                    capture    = 1'b1;
                    next_state = RESP;
                end
            end
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            owner_d    <= 1'b0;
            acc_we     <= 1'b0;
            lat_cnt    <= 4'd0;
            starve_cnt <= 4'd0;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= 32'd0;
            mem_wdata  <= 32'd0;
            if_rdata   <= 32'd0;
            d_rdata    <= 32'd0;
        end else begin
            if (grant_req) begin
                mem_en  <= 1'b1;
                owner_d <= !grant_if;
                lat_cnt <= LAT_INIT;
                if (grant_if) begin
                    mem_we     <= 1'b0;
                    mem_addr   <= if_addr;
                    mem_wdata  <= 32'd0;
                    acc_we     <= 1'b0;
                    starve_cnt <= 4'd0;
                end else begin
                    mem_we    <= d_we;
                    mem_addr  <= d_addr;
                    mem_wdata <= d_wdata;
                    acc_we    <= d_we;
                    if (if_req && (starve_cnt < STARVE_LIM))
                        starve_cnt <= starve_cnt + 4'd1;
                end
            end else if (state == WAIT) begin
                mem_en <= 1'b0;
                mem_we <= 1'b0;
                if (!mem_en && !capture)
                    lat_cnt <= lat_cnt - 4'd1;
                if (capture && !acc_we) begin
                    if (owner_d) d_rdata  <= mem_rdata;
                    else         if_rdata <= mem_rdata;
                end
            end
        end
    end

    assign if_ready  = (state == RESP) && !owner_d;
    assign d_ready   = (state == RESP) && owner_d;
    assign stall_if  = if_req & ~if_ready;
    assign stall_mem = d_req & ~d_ready;
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one instance at MEM_LAT=1 with a modelled memory,
// and one at MEM_LAT=3 whose read data is driven by hand for latency and reset-abort checks.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, d_req, d_we;
    logic [31:0] if_addr, d_addr, d_wdata;
    logic        if_req3, d_req3;
    logic [31:0] mem_rdata, mem_rdata3;

    logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
    logic        if_ready, d_ready, mem_en, mem_we, stall_if, stall_mem, busy;

    logic [31:0] if_rdata3, d_rdata3, mem_addr3, mem_wdata3;
    logic        if_ready3, d_ready3, mem_en3, mem_we3, stall_if3, stall_mem3, busy3;

    logic [31:0] last_st_addr, last_st_data;
    int          total = 0;
    int          bad   = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.MEM_LAT(1), .STARVE_MAX(4)) u_dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ready(d_ready),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .stall_if(stall_if), .stall_mem(stall_mem), .busy(busy)
    );

    mem_port_arbiter #(.MEM_LAT(3), .STARVE_MAX(4)) u_dut3 (
        .clk(clk), .rst(rst),
        .if_req(if_req3), .if_addr(if_addr), .if_rdata(if_rdata3), .if_ready(if_ready3),
        .d_req(d_req3), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata3), .d_ready(d_ready3),
        .mem_en(mem_en3), .mem_we(mem_we3), .mem_addr(mem_addr3), .mem_wdata(mem_wdata3),
        .mem_rdata(mem_rdata3),
        .stall_if(stall_if3), .stall_mem(stall_mem3), .busy(busy3)
    );

    function automatic logic [31:0] rom(input logic [31:0] a);
        case (a)
            32'h00:  return 32'h2008_0005;
            32'h04:  return 32'h3C01_0040;
            32'h08:  return 32'hAC22_0000;
            32'h0C:  return 32'h8C23_0004;
            32'h20:  return 32'h1111_2222;
            default: return {a[15:0], 16'hA5A5};
        endcase
    endfunction

    // Memory for the MEM_LAT=1 instance: read data valid only in the cycle after the command.
    always @(posedge clk) begin
        if (rst) begin
            last_st_addr <= 32'd0;
            last_st_data <= 32'd0;
        end else if (mem_en && mem_we) begin
            last_st_addr <= mem_addr;
            last_st_data <= mem_wdata;
        end
        mem_rdata <= (mem_en && !mem_we) ? rom(mem_addr) : 32'hBADB_AD00;
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic applyStimulus(input logic ifr, input logic [31:0] ia, input logic dr,
                                 input logic we, input logic [31:0] da, input logic [31:0] dw);
        if_req  = ifr;
        if_addr = ia;
        d_req   = dr;
        d_we    = we;
        d_addr  = da;
        d_wdata = dw;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rst        = 1'b1;
        if_req3    = 1'b0;
        d_req3     = 1'b0;
        mem_rdata3 = 32'hBADB_AD00;
        applyStimulus(0, 0, 0, 0, 0, 0);
        tick();
        tick();
        $display("[TB] reset state");
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_mem_en", mem_en, 0);
        checkOutput("rst_mem_addr", mem_addr, 0);
        checkOutput("rst_if_rdata", if_rdata, 0);
        checkOutput("rst_d_rdata", d_rdata, 0);
        checkOutput("rst_ready", {if_ready, d_ready}, 0);
        rst = 1'b0;
        tick();

        $display("[TB] single IF fetch");
        applyStimulus(1, 32'h0, 0, 0, 0, 0);
        checkOutput("f1_stall_c0", stall_if, 1);
        tick();
        checkOutput("f1_mem_en_c1", mem_en, 1);
        checkOutput("f1_mem_addr", mem_addr, 32'h0);
        checkOutput("f1_mem_we", mem_we, 0);
        checkOutput("f1_busy", busy, 1);
        tick();
        checkOutput("f1_mem_en_c2", mem_en, 0);
        checkOutput("f1_ready_c2", if_ready, 0);
        checkOutput("f1_stall_c2", stall_if, 1);
        tick();
        checkOutput("f1_ready_c3", if_ready, 1);
        checkOutput("f1_rdata", if_rdata, 32'h2008_0005);
        checkOutput("f1_stall_c3", stall_if, 0);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("f1_ready_c4", if_ready, 0);
        checkOutput("f1_rdata_hold", if_rdata, 32'h2008_0005);
        checkOutput("f1_idle", busy, 0);
        tick();

        $display("[TB] simultaneous load and fetch");
        applyStimulus(1, 32'h4, 1, 0, 32'h20, 0);
        tick();
        checkOutput("sim_d_first_addr", mem_addr, 32'h20);
        tick();
        tick();
        checkOutput("sim_d_ready", d_ready, 1);
        checkOutput("sim_d_rdata", d_rdata, 32'h1111_2222);
        checkOutput("sim_if_wait", if_ready, 0);
        checkOutput("sim_stall_if", stall_if, 1);
        checkOutput("sim_stall_mem", stall_mem, 0);
        tick();
        applyStimulus(1, 32'h4, 0, 0, 0, 0);
        tick();
        checkOutput("sim_if_addr", mem_addr, 32'h4);
        checkOutput("sim_if_en", mem_en, 1);
        tick();
        checkOutput("sim_if_ready_early", if_ready, 0);
        tick();
        checkOutput("sim_if_ready", if_ready, 1);
        checkOutput("sim_if_rdata", if_rdata, 32'h3C01_0040);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0);
        tick();

        $display("[TB] store");
        applyStimulus(0, 0, 1, 1, 32'h10, 32'hDEAD_BEEF);
        tick();
        checkOutput("st_en", mem_en, 1);
        checkOutput("st_we", mem_we, 1);
        checkOutput("st_addr", mem_addr, 32'h10);
        checkOutput("st_wdata", mem_wdata, 32'hDEAD_BEEF);
        tick();
        checkOutput("st_en_off", mem_en, 0);
        checkOutput("st_we_off", mem_we, 0);
        checkOutput("st_addr_hold", mem_addr, 32'h10);
        tick();
        checkOutput("st_ready", d_ready, 1);
        checkOutput("st_rdata_kept", d_rdata, 32'h1111_2222);
        checkOutput("st_mem_addr", last_st_addr, 32'h10);
        checkOutput("st_mem_data", last_st_data, 32'hDEAD_BEEF);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("st_ready_off", d_ready, 0);
        tick();

        $display("[TB] starvation");
        applyStimulus(1, 32'h8, 1, 0, 32'h20, 0);
        for (int k = 0; k < 4; k++) begin
            tick();
            checkOutput("stv_d_en", mem_en, 1);
            checkOutput("stv_d_addr", mem_addr, 32'h20);
            tick();
            tick();
            checkOutput("stv_d_ready", d_ready, 1);
            checkOutput("stv_stall_if", stall_if, 1);
            tick();
        end
        tick();
        checkOutput("stv_if_addr", mem_addr, 32'h8);
        checkOutput("stv_if_we", mem_we, 0);
        checkOutput("stv_if_wdata", mem_wdata, 0);
        tick();
        tick();
        checkOutput("stv_if_ready", if_ready, 1);
        checkOutput("stv_if_rdata", if_rdata, 32'hAC22_0000);
        checkOutput("stv_stall_mem", stall_mem, 1);
        tick();
        applyStimulus(1, 32'hC, 1, 0, 32'h20, 0);
        tick();
        checkOutput("stv_cnt_cleared", mem_addr, 32'h20);
        tick();
        tick();
        checkOutput("stv_d_ready2", d_ready, 1);
        tick();
        applyStimulus(1, 32'hC, 0, 0, 0, 0);
        tick();
        checkOutput("stv_if2_addr", mem_addr, 32'hC);
        tick();
        tick();
        checkOutput("stv_if2_rdata", if_rdata, 32'h8C23_0004);
        checkOutput("stv_if2_ready", if_ready, 1);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0);
        tick();

        $display("[TB] back-to-back fetches");
        applyStimulus(1, 32'h0, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            logic [31:0] a;
            a = 32'(k * 4);
            tick();
            checkOutput("b2b_en", mem_en, 1);
            checkOutput("b2b_addr", mem_addr, a);
            tick();
            checkOutput("b2b_en_gap1", mem_en, 0);
            tick();
            checkOutput("b2b_en_gap2", mem_en, 0);
            checkOutput("b2b_ready", if_ready, 1);
            checkOutput("b2b_rdata", if_rdata, rom(a));
            tick();
            if (k < 2) applyStimulus(1, a + 32'h4, 0, 0, 0, 0);
            else       applyStimulus(0, 0, 0, 0, 0, 0);
            checkOutput("b2b_en_gap3", mem_en, 0);
        end
        tick();

        $display("[TB] reset during WAIT, MEM_LAT=3");
        if_req3 = 1'b1;
        if_addr = 32'h40;
        tick();
        checkOutput("r3_en", mem_en3, 1);
        checkOutput("r3_addr", mem_addr3, 32'h40);
        tick();
        checkOutput("r3_wait_busy", busy3, 1);
        checkOutput("r3_wait_en", mem_en3, 0);
        rst = 1'b1;
        tick();
        checkOutput("r3_busy", busy3, 0);
        checkOutput("r3_mem_en", mem_en3, 0);
        checkOutput("r3_mem_addr", mem_addr3, 0);
        checkOutput("r3_if_rdata", if_rdata3, 0);
        checkOutput("r3_ready", {if_ready3, d_ready3}, 0);
        rst     = 1'b0;
        if_req3 = 1'b0;
        for (int k = 0; k < 6; k++) begin
            mem_rdata3 = 32'h1000_0000 + 32'(k);
            tick();
            checkOutput("r3_no_ready", {if_ready3, d_ready3, busy3}, 0);
            checkOutput("r3_rdata_zero", if_rdata3, 0);
        end

        $display("[TB] fetch, MEM_LAT=3");
        mem_rdata3 = 32'hBADB_AD00;
        if_req3    = 1'b1;
        if_addr    = 32'h44;
        tick();
        checkOutput("l3_en", mem_en3, 1);
        tick();
        tick();
        checkOutput("l3_ready_c3", if_ready3, 0);
        tick();
        mem_rdata3 = 32'hCAFE_0044;
        checkOutput("l3_ready_c4", if_ready3, 0);
        tick();
        mem_rdata3 = 32'hBADB_AD00;
        checkOutput("l3_ready_c5", if_ready3, 1);
        checkOutput("l3_rdata", if_rdata3, 32'hCAFE_0044);
        tick();
        if_req3 = 1'b0;
        checkOutput("l3_ready_off", if_ready3, 0);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
